// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: EX/MEM -> data memory -> WB stage controller.
// ex_*: EX valid/ready bundle in; Address/Writedata/MemRead/MemWrite/Readdata:
// word memory port; wb_*: registered result out (valid/ready).
// Optional define MEM_PERF_CNT_EN adds perf_loads/perf_stores/perf_stall_cycles.
module mem_stage_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 65,
  parameter int RD_W        = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [31:0]     ex_alu_result,
  input  logic [31:0]     ex_store_data,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic            ex_reg_write,
  input  logic            ex_mem_to_reg,
  input  logic [RD_W-1:0] ex_rd,
  output logic [31:0]     Address,
  output logic [31:0]     Writedata,
  output logic            MemRead,
  output logic            MemWrite,
  input  logic [31:0]     Readdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [31:0]     wb_read_data,
  output logic [31:0]     wb_alu_result,
  output logic            wb_reg_write,
  output logic            wb_mem_to_reg,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_fault
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]     perf_loads,
  output logic [31:0]     perf_stores,
  output logic [31:0]     perf_stall_cycles
`endif
);

  localparam int WC = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CW = (WC > 1) ? $clog2(WC) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WC - 1);
  localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          up;
  logic          rd_op;
  logic          wr_op;

  logic acc;
  logic mem_op;
  logic fault;
  logic last;

  // up keeps ex_ready low until the first clock after reset release.
  assign ex_ready = up & ((state == IDLE) |
                          ((state == RESP) & wb_ready));
  assign acc    = ex_valid & ex_ready;
  assign mem_op = ex_mem_read | ex_mem_write;
  assign fault  = mem_op & (ex_alu_result >= DEPTH);
  assign last   = (state == ACCESS) & (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      up            <= 1'b0;
      rd_op         <= 1'b0;
      wr_op         <= 1'b0;
      Address       <= '0;
      Writedata     <= '0;
      MemRead       <= 1'b0;
      MemWrite      <= 1'b0;
      wb_valid      <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_rd         <= '0;
      wb_fault      <= 1'b0;
    end else begin
      up <= 1'b1;
      unique case (state)
        ACCESS: begin
          if (cnt == '0) begin
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            if (rd_op && !wr_op)
              wb_read_data <= Readdata;
            wb_valid <= 1'b1;
            state    <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: ;
      endcase
      // Accept overrides the RESP->IDLE step for back-to-back issue.
      if (acc) begin
        rd_op         <= ex_mem_read;
        wr_op         <= ex_mem_write;
        wb_alu_result <= ex_alu_result;
        wb_rd         <= ex_rd;
        wb_mem_to_reg <= ex_mem_to_reg;
        wb_reg_write  <= ex_reg_write & ~fault;
        wb_fault      <= fault;
        wb_read_data  <= '0;
        if (!mem_op || fault) begin
          state    <= RESP;
          wb_valid <= 1'b1;
        end else begin
          state     <= ACCESS;
          wb_valid  <= 1'b0;
          cnt       <= CNT_INIT;
          Address   <= ex_alu_result;
          Writedata <= ex_mem_write ? ex_store_data : '0;
          // A write wins when both read and write are set.
          MemWrite  <= ex_mem_write;
          MemRead   <= ~ex_mem_write;
        end
      end
    end
  end

`ifdef MEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads        <= '0;
      perf_stores       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (last && !wr_op && perf_loads != '1)
        perf_loads <= perf_loads + 32'd1;
      if (last && wr_op && perf_stores != '1)
        perf_stores <= perf_stores + 32'd1;
      if (ex_valid && !ex_ready &&
          perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench for mem_stage_ctrl.
// Random and directed traffic against a transaction-level memory model.
module tb_mem_stage_ctrl;

  localparam int W     = 2;
  localparam int DEPTH = 65;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_store_data = '0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic        ex_reg_write = 1'b0;
  logic        ex_mem_to_reg = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] Address;
  logic [31:0] Writedata;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Readdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_read_data;
  logic [31:0] wb_alu_result;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic [4:0]  wb_rd;
  logic        wb_fault;

  mem_stage_ctrl #(
    .WAIT_CYCLES(W),
    .DEPTH_WORDS(DEPTH),
    .RD_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ex_valid(ex_valid),
    .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg),
    .ex_rd(ex_rd),
    .Address(Address),
    .Writedata(Writedata),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .Readdata(Readdata),
    .wb_valid(wb_valid),
    .wb_ready(wb_ready),
    .wb_read_data(wb_read_data),
    .wb_alu_result(wb_alu_result),
    .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg),
    .wb_rd(wb_rd),
    .wb_fault(wb_fault)
  );

  always #5 clk = ~clk;

  // Word memory the DUT talks to.
  logic [31:0] mem [0:127];
  assign Readdata = mem[Address[6:0]];
  always @(posedge clk)
    if (MemWrite) mem[Address[6:0]] <= Writedata;

  // Reference memory, updated per accepted transaction.
  logic [31:0] ref_mem [0:127];

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic        rw;
    logic        m2r;
    logic        fault;
    logic [4:0]  rd;
    int          lat;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } stb_t;

  exp_t q[$];
  stb_t sq[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic rnd_bp = 1'b0;
  logic bp_hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               nm, act, want, $time);
    end
  endtask

  initial begin
    wb_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_hold) wb_ready = 1'b0;
      else if (rnd_bp)
        wb_ready = ($urandom_range(0, 3) != 0);
      else wb_ready = 1'b1;
    end
  end

  task automatic send(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic r,
                      input logic w,
                      input logic rw,
                      input logic m2r,
                      input logic [4:0] rd);
    int   n;
    exp_t e;
    stb_t s;
    logic flt;
    ex_alu_result = a;
    ex_store_data = d;
    ex_mem_read   = r;
    ex_mem_write  = w;
    ex_reg_write  = rw;
    ex_mem_to_reg = m2r;
    ex_rd         = rd;
    ex_valid      = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ex_ready && n < 200);
    if (!ex_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      flt       = (r || w) && (a >= DEPTH);
      e.fault   = flt;
      e.rw      = rw && !flt;
      e.m2r     = m2r;
      e.rd      = rd;
      e.alu     = a;
      e.rdata   = (r && !w && !flt) ? ref_mem[a[6:0]] : '0;
      e.lat     = ((r || w) && !flt) ? 1 + W : 1;
      e.acc_cyc = cyc;
      if (w && !flt) ref_mem[a[6:0]] = d;
      q.push_back(e);
      if ((r || w) && !flt) begin
        s.wr    = w;
        s.addr  = a;
        s.wdata = w ? d : '0;
        sq.push_back(s);
      end
    end
    @(posedge clk);
    #1 ex_valid = 1'b0;
  endtask

  // Monitor: strobe shape, WB presentation, hold and handshake rules.
  initial begin : monitor
    exp_t        e;
    stb_t        cur;
    int          run;
    logic        pv;
    logic        phs;
    logic [31:0] last_addr;
    logic [31:0] last_wd;
    logic [31:0] s_rdat;
    logic [31:0] s_alu;
    logic [4:0]  s_rd;
    logic [2:0]  s_ctl;
    run = 0;
    pv = 1'b0;
    phs = 1'b0;
    last_addr = '0;
    last_wd = '0;
    cur.wr = 1'b0;
    cur.addr = '0;
    cur.wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        sq.delete();
        run = 0;
        pv = 1'b0;
        phs = 1'b0;
        last_addr = '0;
        last_wd = '0;
        continue;
      end
      if (MemRead || MemWrite) begin
        chk("one_strobe", 32'(MemRead & MemWrite), 0);
        chk("ex_ready_access", 32'(ex_ready), 0);
        if (run == 0) begin
          if (sq.size() == 0) begin
            chk("spurious_strobe", 1, 0);
          end else begin
            cur = sq.pop_front();
            chk("strobe_write", 32'(MemWrite), 32'(cur.wr));
            chk("strobe_addr", Address, cur.addr);
            chk("strobe_wdata", Writedata, cur.wdata);
          end
        end else begin
          chk("strobe_hold_addr", Address, last_addr);
          chk("strobe_hold_wr", 32'(MemWrite), 32'(cur.wr));
        end
        run++;
      end else begin
        if (run != 0) chk("strobe_len", run, W);
        run = 0;
        chk("addr_hold", Address, last_addr);
        chk("wdata_hold", Writedata, last_wd);
      end
      last_addr = Address;
      last_wd = Writedata;

      if (wb_valid) begin
        if (!pv || phs) begin
          if (q.size() == 0) begin
            chk("unexpected_wb", 1, 0);
          end else begin
            e = q[0];
            chk("latency", cyc - e.acc_cyc, e.lat);
          end
        end else begin
          chk("hold_rdata", wb_read_data, s_rdat);
          chk("hold_alu", wb_alu_result, s_alu);
          chk("hold_rd", 32'(wb_rd), 32'(s_rd));
          chk("hold_ctl",
              32'({wb_reg_write, wb_mem_to_reg, wb_fault}),
              32'(s_ctl));
        end
        if (!wb_ready) begin
          chk("ex_ready_bp", 32'(ex_ready), 0);
        end else begin
          chk("ex_ready_release", 32'(ex_ready), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("rdata", wb_read_data, e.rdata);
            chk("alu", wb_alu_result, e.alu);
            chk("rd", 32'(wb_rd), 32'(e.rd));
            chk("reg_write", 32'(wb_reg_write), 32'(e.rw));
            chk("mem_to_reg", 32'(wb_mem_to_reg), 32'(e.m2r));
            chk("fault", 32'(wb_fault), 32'(e.fault));
          end
        end
        s_rdat = wb_read_data;
        s_alu = wb_alu_result;
        s_rd = wb_rd;
        s_ctl = {wb_reg_write, wb_mem_to_reg, wb_fault};
      end
      pv = wb_valid;
      phs = wb_valid && wb_ready;
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ex_ready"}, 32'(ex_ready), 0);
    chk({nm, "_addr"}, Address, 0);
    chk({nm, "_wdata"}, Writedata, 0);
    chk({nm, "_strobes"}, 32'({MemRead, MemWrite}), 0);
    chk({nm, "_wb_valid"}, 32'(wb_valid), 0);
    chk({nm, "_wb_rdata"}, wb_read_data, 0);
    chk({nm, "_wb_alu"}, wb_alu_result, 0);
    chk({nm, "_wb_ctl"},
        32'({wb_reg_write, wb_mem_to_reg, wb_fault, wb_rd}), 0);
  endtask

  initial begin
    logic [31:0] saved;
    logic [31:0] a;
    logic [31:0] d;
    logic        r;
    logic        w;
    int          k;
    int          n;

    for (int i = 0; i < 128; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[3] = 32'd47;
    ref_mem[3] = 32'd47;

    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    #1 chk("ex_ready_pre_clk", 32'(ex_ready), 0);
    @(posedge clk);
    #1 chk("ex_ready_post_clk", 32'(ex_ready), 1);

    // Reset during the first strobe cycle of a store.
    saved = mem[10];
    ex_alu_result = 32'd10;
    ex_store_data = ~saved;
    ex_mem_write = 1'b1;
    ex_valid = 1'b1;
    @(negedge clk);
    chk("rst_accept", 32'(ex_ready), 1);
    @(posedge clk);
    #1 ex_valid = 1'b0;
    ex_mem_write = 1'b0;
    chk("rst_strobe_on", 32'(MemWrite), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_mem_kept", mem[10], saved);
    chk("rst_idle_ready", 32'(ex_ready), 1);
    chk("rst_idle_wb", 32'(wb_valid), 0);
    chk("rst_idle_strobe", 32'({MemRead, MemWrite}), 0);

    // Directed cases.
    send(32'd3, 32'hdead_beef, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
    send(32'd5, 32'h55, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    send(32'd5, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
    send(32'd65, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
    send(32'd64, 32'h77, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
    send(32'd64, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
    send(32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7);

    // Backpressure: result held while WB stalls, next accepted on release.
    bp_hold = 1'b1;
    send(32'h00ab_cdef, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd11);
    fork
      send(32'd7, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12);
      begin
        repeat (5) @(posedge clk);
        bp_hold = 1'b0;
      end
    join

    // Random traffic with random WB backpressure.
    rnd_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 7);
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = 32'($urandom_range(0, DEPTH + 2));
      d = $urandom;
      r = (k == 1 || k == 2 || k == 6);
      w = (k == 3 || k == 4 || k == 6);
      send(a, d, r, w, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rnd_bp = 1'b0;

    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
